// File: rtl/loader_pkg.sv
// Shared constants for the instruction loader: FSM state codes, default widths
// and the default end-of-program word.
package loader_pkg;

  localparam int unsigned DEFAULT_UART_BUS_SIZE        = 8;
  localparam int unsigned DEFAULT_INSTRUCTION_BUS_SIZE = 32;
  localparam int unsigned DEFAULT_COUNT_BUS_SIZE       = 7;
  localparam int unsigned BYTES_PER_WORD =
      DEFAULT_INSTRUCTION_BUS_SIZE / DEFAULT_UART_BUS_SIZE;

  localparam logic [31:0] HALT_INSTRUCTION_DEFAULT = 32'hFFFF_FFFF;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StClear   = 3'd1;
  localparam state_t StReceive = 3'd2;
  localparam state_t StPop     = 3'd3;
  localparam state_t StCheck   = 3'd4;
  localparam state_t StWrite   = 3'd5;
  localparam state_t StDone    = 3'd6;
  localparam state_t StError   = 3'd7;

  function automatic logic is_busy_state(state_t s);
    return (s == StClear) || (s == StReceive) || (s == StPop) ||
           (s == StCheck) || (s == StWrite);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte packer: each shift pushes a byte in at the LSB end, so the
// first byte of a word ends up in the top bits once the word is complete.
module word_assembler #(
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned WordWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift,
  input  logic                 clear,
  input  logic [ByteWidth-1:0] data_byte,
  output logic [WordWidth-1:0] word,
  output logic                 last_byte
);

  localparam int unsigned BytesPerWord = WordWidth / ByteWidth;
  localparam int unsigned IdxWidth     = $clog2(BytesPerWord + 1);

  logic [IdxWidth-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word  <= '0;
      idx_q <= '0;
    end else if (shift) begin
      word  <= {word[WordWidth-ByteWidth-1:0], data_byte};
      idx_q <= idx_q + 1'b1;
    end
  end

  // idx_q counts bytes already shifted in, so this is high in the POP after the final byte.
  assign last_byte = (idx_q == IdxWidth'(BytesPerWord));

endmodule

// File: rtl/instruction_loader.sv
// Loads the MIPS instruction memory from the UART RX FIFO: clear, then pack
// bytes big-endian into words and write them until the halt word is stored.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned UART_BUS_SIZE        = DEFAULT_UART_BUS_SIZE,
  parameter int unsigned INSTRUCTION_BUS_SIZE = DEFAULT_INSTRUCTION_BUS_SIZE,
  parameter int unsigned COUNT_BUS_SIZE       = DEFAULT_COUNT_BUS_SIZE,
  parameter logic [INSTRUCTION_BUS_SIZE-1:0] HALT_INSTRUCTION = HALT_INSTRUCTION_DEFAULT
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic                            i_uart_empty,
  input  logic [UART_BUS_SIZE-1:0]        i_uart_data_rd,
  input  logic                            i_ins_mem_full,
  output logic                            o_uart_rd,
  output logic                            o_clear_program,
  output logic                            o_ins_mem_wr,
  output logic [INSTRUCTION_BUS_SIZE-1:0] o_ins,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error,
  output logic [COUNT_BUS_SIZE-1:0]       o_word_count
);

  state_t                          state_q, state_d;
  logic                            asm_shift, asm_clear, asm_last;
  logic                            start_load;
  logic [INSTRUCTION_BUS_SIZE-1:0] asm_word;

  word_assembler #(
    .ByteWidth(UART_BUS_SIZE),
    .WordWidth(INSTRUCTION_BUS_SIZE)
  ) u_word_assembler (
    .clk      (i_clk),
    .reset    (i_reset),
    .shift    (asm_shift),
    .clear    (asm_clear),
    .data_byte(i_uart_data_rd),
    .word     (asm_word),
    .last_byte(asm_last)
  );

  always_comb begin
    state_d    = state_q;
    asm_shift  = 1'b0;
    asm_clear  = 1'b0;
    start_load = 1'b0;
    if (i_abort) begin
      state_d   = StIdle;
      asm_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (i_start) begin
            state_d    = StClear;
            start_load = 1'b1;
            asm_clear  = 1'b1;
          end else if (state_q == StDone) begin
            state_d = StIdle;
          end
        end
        StClear: state_d = StReceive;
        StReceive: begin
          if (!i_uart_empty) begin
            asm_shift = 1'b1;
            state_d   = StPop;
          end
        end
        // The POP cycle lets the FIFO empty flag settle before the next sample.
        StPop:   state_d = asm_last ? StCheck : StReceive;
        StCheck: state_d = i_ins_mem_full ? StError : StWrite;
        StWrite: begin
          if (asm_word == HALT_INSTRUCTION) begin
            state_d = StDone;
          end else begin
            asm_clear = 1'b1;
            state_d   = StReceive;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Every output is a registered decode of the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= StIdle;
      o_uart_rd       <= 1'b0;
      o_clear_program <= 1'b0;
      o_ins_mem_wr    <= 1'b0;
      o_ins           <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_error         <= 1'b0;
      o_word_count    <= '0;
    end else begin
      state_q         <= state_d;
      o_uart_rd       <= asm_shift;
      o_clear_program <= (state_d == StClear);
      o_ins_mem_wr    <= (state_d == StWrite);
      o_busy          <= is_busy_state(state_d);
      o_done          <= (state_d == StDone);
      if (state_d == StWrite) begin
        o_ins <= asm_word;
        if (!(&o_word_count)) begin
          o_word_count <= o_word_count + 1'b1;
        end
      end
      if (start_load) begin
        o_word_count <= '0;
        o_error      <= 1'b0;
      end else if ((state_q == StCheck) && (state_d == StError)) begin
        o_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: a queue-based UART FIFO model feeds the DUT and
// a word-level reference model predicts what gets written to instruction memory.
module tb_instruction_loader;
  import loader_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_abort, i_uart_empty, i_ins_mem_full;
  logic [7:0]  i_uart_data_rd;
  logic        o_uart_rd, o_clear_program, o_ins_mem_wr, o_busy, o_done, o_error;
  logic [31:0] o_ins;
  logic [6:0]  o_word_count;

  instruction_loader dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_uart_empty   (i_uart_empty),
    .i_uart_data_rd (i_uart_data_rd),
    .i_ins_mem_full (i_ins_mem_full),
    .o_uart_rd      (o_uart_rd),
    .o_clear_program(o_clear_program),
    .o_ins_mem_wr   (o_ins_mem_wr),
    .o_ins          (o_ins),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_word_count   (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment state
  logic [7:0]  prog[$];
  logic [7:0]  fifo[$];
  int          hold, gap, full_after, writes_seen, cyc, start_step;
  logic [31:0] wr_log[$];
  int          rd_steps[$], wr_steps[$];
  int          rd_cnt, clr_cnt, done_cnt, clr_step, done_step;
  bit          rd_prev, rd_while_empty, rd_back_to_back;

  // Reference model results
  logic [31:0] m_words[$];
  int          m_pops;
  bit          m_done, m_err;

  typedef struct {
    logic [127:0] bytes;
    int           n_bytes;
    int           gap;
    int           full_after;
    int           exp_count;
    int           exp_done;
    int           exp_error;
    int           exp_pops;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    i_uart_empty   = (fifo.size() == 0) || (hold > 0);
    i_uart_data_rd = (fifo.size() != 0) ? fifo[0] : 8'h00;
    i_ins_mem_full = (full_after >= 0) && (writes_seen >= full_after);
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    logic empty_before;
    empty_before = i_uart_empty;
    @(posedge i_clk);
    #1;
    cyc++;
    if (hold > 0) hold--;
    if (rd_prev && fifo.size() > 0) begin
      void'(fifo.pop_front());
      hold = gap;
    end
    if (o_uart_rd) begin
      rd_cnt++;
      rd_steps.push_back(cyc);
      if (rd_prev) rd_back_to_back = 1'b1;
      if (empty_before) rd_while_empty = 1'b1;
    end
    rd_prev = o_uart_rd;
    if (o_clear_program) begin
      clr_cnt++;
      clr_step = cyc;
    end
    if (o_ins_mem_wr) begin
      wr_log.push_back(o_ins);
      wr_steps.push_back(cyc);
      writes_seen++;
    end
    if (o_done) begin
      done_cnt++;
      done_step = cyc;
    end
    drive();
  endtask

  // Words are aligned 4-byte groups, big-endian; memory is full after full_after writes.
  task automatic model();
    m_words.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_pops = 0;
    for (int w = 0; 4 * w + 3 < prog.size(); w++) begin
      logic [31:0] word;
      word = {prog[4*w], prog[4*w+1], prog[4*w+2], prog[4*w+3]};
      m_pops += 4;
      if (full_after >= 0 && w >= full_after) begin
        m_err = 1'b1;
        break;
      end
      m_words.push_back(word);
      if (word == 32'hFFFF_FFFF) begin
        m_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic begin_load();
    fifo = prog;
    wr_log.delete();
    rd_steps.delete();
    wr_steps.delete();
    rd_cnt = 0; clr_cnt = 0; done_cnt = 0; writes_seen = 0; hold = 0;
    clr_step = -1; done_step = -1;
    rd_while_empty = 1'b0; rd_back_to_back = 1'b0;
    drive();
    i_start = 1'b1;
    step();
    start_step = cyc;
    i_start = 1'b0;
  endtask

  task automatic run_load(input int budget);
    bit timed_out;
    timed_out = 1'b0;
    begin_load();
    while (done_cnt == 0 && o_error !== 1'b1) begin
      if (cyc - start_step >= budget) begin
        timed_out = 1'b1;
        break;
      end
      step();
    end
    check("load_terminates", timed_out, 0);
  endtask

  task automatic compare_load(input string tag);
    check({tag, "_count"}, o_word_count, m_words.size());
    check({tag, "_error"}, o_error, m_err);
    check({tag, "_done_pulses"}, done_cnt, m_done);
    check({tag, "_pops"}, rd_cnt, m_pops);
    check({tag, "_clear_pulses"}, clr_cnt, 1);
    check({tag, "_nwords"}, wr_log.size(), m_words.size());
    for (int k = 0; k < wr_log.size() && k < m_words.size(); k++)
      check($sformatf("%s_word%0d", tag, k), wr_log[k], m_words[k]);
    check({tag, "_pop_while_empty"}, rd_while_empty, 0);
    check({tag, "_pop_back_to_back"}, rd_back_to_back, 0);
  endtask

  task automatic set_prog(input logic [127:0] bv, input int n);
    prog.delete();
    for (int j = 0; j < n; j++) prog.push_back(bv[127-8*j -: 8]);
  endtask

  initial begin
    vecs[0] = '{bytes: 128'h20010005_FFFFFFFF_00000000_00000000, n_bytes: 8, gap: 0,
                full_after: -1, exp_count: 2, exp_done: 1, exp_error: 0, exp_pops: 8};
    vecs[1] = '{bytes: 128'h20010005_FFFFFFFF_00000000_00000000, n_bytes: 8, gap: 50,
                full_after: -1, exp_count: 2, exp_done: 1, exp_error: 0, exp_pops: 8};
    vecs[2] = '{bytes: 128'h11223344_55667788_99AABBCC_FFFFFFFF, n_bytes: 16, gap: 0,
                full_after: 3, exp_count: 3, exp_done: 0, exp_error: 1, exp_pops: 16};
    vecs[3] = '{bytes: 128'h00FFFFFF_FF000000_FFFFFFFF_00000000, n_bytes: 12, gap: 1,
                full_after: -1, exp_count: 3, exp_done: 1, exp_error: 0, exp_pops: 12};
    vecs[4] = '{bytes: 128'hFFFFFFFF_00000000_00000000_00000000, n_bytes: 4, gap: 2,
                full_after: -1, exp_count: 1, exp_done: 1, exp_error: 0, exp_pops: 4};

    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    full_after = -1; gap = 0; hold = 0; cyc = 0; writes_seen = 0; rd_prev = 1'b0;
    drive();
    repeat (2) step();
    check("reset_ctrl_outputs",
          {o_uart_rd, o_clear_program, o_ins_mem_wr, o_busy, o_done, o_error, o_word_count}, 0);
    check("reset_ins", o_ins, 0);
    check("reset_state", dut.state_q, StIdle);
    i_reset = 1'b0;
    step();

    // Table-driven loads
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      set_prog(vecs[i].bytes, vecs[i].n_bytes);
      gap = vecs[i].gap;
      full_after = vecs[i].full_after;
      model();
      run_load(3000);
      check({tag, "_tbl_count"}, o_word_count, vecs[i].exp_count);
      check({tag, "_tbl_done"}, done_cnt, vecs[i].exp_done);
      check({tag, "_tbl_error"}, o_error, vecs[i].exp_error);
      check({tag, "_tbl_pops"}, rd_cnt, vecs[i].exp_pops);
      compare_load(tag);
      if (vecs[i].exp_error != 0) begin
        check({tag, "_state_error"}, dut.state_q, StError);
        step();
        check({tag, "_error_sticky"}, o_error, 1);
      end
      if (i == 0) begin
        // step index k shows the cycle after edge k
        check("v0_clear_timing", clr_step, start_step);
        check("v0_timing_samples", wr_steps.size(), 2);
        if (rd_steps.size() >= 4 && wr_steps.size() >= 2) begin
          check("v0_first_pop_timing", rd_steps[0], start_step + 2);
          check("v0_write_after_4th_pop", wr_steps[0], rd_steps[3] + 2);
          check("v0_word_period", wr_steps[1] - wr_steps[0], 10);
          check("v0_done_after_halt", done_step, wr_steps[1] + 1);
        end
      end
      step();
      check({tag, "_idle_after"}, o_busy, 0);
    end

    // Memory full, then restart from ERROR
    set_prog(vecs[2].bytes, 16);
    gap = 0; full_after = 3;
    run_load(3000);
    check("full_error_set", o_error, 1);
    check("full_count", o_word_count, 3);
    full_after = -1;
    prog.delete();
    fifo.delete();
    i_start = 1'b1;
    drive();
    step();
    i_start = 1'b0;
    check("restart_error_cleared", o_error, 0);
    check("restart_clear_pulse", o_clear_program, 1);
    check("restart_count_cleared", o_word_count, 0);

    // Start while busy is ignored; start with abort yields IDLE
    repeat (3) step();
    check("busy_waiting", o_busy, 1);
    i_start = 1'b1;
    step();
    check("busy_start_no_clear", o_clear_program, 0);
    check("busy_start_state", dut.state_q, StReceive);
    i_abort = 1'b1;
    step();
    check("start_abort_state", dut.state_q, StIdle);
    check("start_abort_busy", o_busy, 0);
    check("start_abort_no_clear", o_clear_program, 0);
    step();
    check("start_abort_idle_state", dut.state_q, StIdle);
    check("start_abort_idle_no_clear", o_clear_program, 0);
    i_start = 1'b0;
    i_abort = 1'b0;
    step();

    // Abort two bytes into the second word
    set_prog(128'h01020304_AABBCCDD_00000000_00000000, 8);
    gap = 0; full_after = -1;
    begin_load();
    while (rd_cnt < 6 && cyc - start_step < 500) step();
    check("abort_reached_bytes", rd_cnt, 6);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("abort_state_idle", dut.state_q, StIdle);
    check("abort_no_write", o_ins_mem_wr, 0);
    check("abort_count_kept", o_word_count, 1);
    check("abort_not_busy", o_busy, 0);
    repeat (3) step();
    check("abort_writes", wr_log.size(), 1);
    if (wr_log.size() > 0) check("abort_first_word", wr_log[0], 32'h01020304);
    set_prog(128'h12345678_FFFFFFFF_00000000_00000000, 8);
    model();
    run_load(3000);
    compare_load("after_abort");

    // Reset during WRITE
    set_prog(128'h20010005_FFFFFFFF_00000000_00000000, 8);
    begin_load();
    while (o_ins_mem_wr !== 1'b1 && cyc - start_step < 500) step();
    check("reset_reached_write", o_ins_mem_wr, 1);
    i_reset = 1'b1;
    step();
    check("midreset_ctrl_outputs",
          {o_uart_rd, o_clear_program, o_ins_mem_wr, o_busy, o_done, o_error, o_word_count}, 0);
    check("midreset_ins", o_ins, 0);
    check("midreset_state", dut.state_q, StIdle);
    i_reset = 1'b0;
    rd_prev = 1'b0;
    step();

    // Randomized programs against the reference model
    for (int r = 0; r < 20; r++) begin
      int n;
      logic [31:0] word;
      n = $urandom_range(1, 6);
      prog.delete();
      for (int w = 0; w < n; w++) begin
        if (w == n - 1) word = 32'hFFFF_FFFF;
        else begin
          word = $urandom;
          while (word == 32'hFFFF_FFFF) word = $urandom;
        end
        for (int b = 3; b >= 0; b--) prog.push_back(word[8*b +: 8]);
      end
      gap = $urandom_range(0, 3);
      full_after = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      model();
      run_load(3000);
      compare_load($sformatf("rnd%0d", r));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
